// File: rtl/posit_unpacker_pipe_if.sv
// Handshake bundle for posit_unpacker_pipe: raw posit words in, decoded fields out.
interface posit_unpacker_pipe_if #(
  parameter int BITS = 32,
  parameter int ES   = 3
);
  localparam int RW = $clog2(BITS) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [BITS-1:0]      in_data;

  logic                 out_valid;
  logic                 out_ready;
  logic                 out_sign;
  logic                 out_zero;
  logic                 out_nar;
  logic signed [RW-1:0] out_regime;
  logic [ES-1:0]        out_exp;
  logic [BITS-1:0]      out_frac;

  // Producer/consumer side that feeds words and accepts decoded fields.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_sign, out_zero, out_nar,
           out_regime, out_exp, out_frac
  );

  // The unpacker itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_sign, out_zero, out_nar,
           out_regime, out_exp, out_frac
  );
endinterface

// File: rtl/posit_unpacker_pipe.sv
// Two-stage posit unpacker: stage 1 captures sign, special flags and the
// absolute value; stage 2 decodes regime, exponent and fraction into
// registered outputs. Valid/ready handshake on both sides.
module posit_unpacker_pipe #(
  parameter int BITS = 32,
  parameter int ES   = 3
) (
  input logic                  clk,
  input logic                  rst,
  posit_unpacker_pipe_if.slave bus
);
  localparam int RW = $clog2(BITS) + 1;
  localparam logic [BITS-1:0] NAR_WORD = {1'b1, {(BITS-1){1'b0}}};

  logic            s1_valid;
  logic            s1_sign;
  logic            s1_zero;
  logic            s1_nar;
  logic [BITS-1:0] s1_abs;

  logic            s2_advance;
  logic            s1_advance;

  logic                 run_bit;
  logic                 run_done;
  int                   run_len;
  logic [BITS-1:0]      rest;
  logic signed [RW-1:0] k_val;
  logic [ES-1:0]        exp_val;
  logic [BITS-1:0]      frac_val;

  // Pipeline flow control; in_ready is held low during reset so nothing is taken then.
  always_comb begin
    s2_advance   = !bus.out_valid || bus.out_ready;
    s1_advance   = s1_valid && s2_advance;
    bus.in_ready = !rst && (!s1_valid || s1_advance);
  end

  // Stage 1: capture sign, zero/NaR flags and two's-complement magnitude.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_nar   <= 1'b0;
      s1_abs   <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign <= bus.in_data[BITS-1];
        s1_zero <= (bus.in_data == '0);
        s1_nar  <= (bus.in_data == NAR_WORD);
        s1_abs  <= bus.in_data[BITS-1] ? -bus.in_data : bus.in_data;
      end
    end
  end

  // Regime run-length count, then shift out sign, run and terminator to expose exp/frac.
  always_comb begin
    run_bit  = s1_abs[BITS-2];
    run_done = 1'b0;
    run_len  = 0;
    for (int i = BITS - 2; i >= 0; i--) begin
      if (!run_done && (s1_abs[i] == run_bit)) begin
        run_len = run_len + 1;
      end else begin
        run_done = 1'b1;
      end
    end
    rest     = s1_abs << (run_len + 2);
    k_val    = run_bit ? RW'(run_len - 1) : RW'(-run_len);
    exp_val  = rest[BITS-1 -: ES];
    frac_val = rest << ES;
  end

  // Stage 2: register decoded fields; holds everything while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_sign   <= 1'b0;
      bus.out_zero   <= 1'b0;
      bus.out_nar    <= 1'b0;
      bus.out_regime <= '0;
      bus.out_exp    <= '0;
      bus.out_frac   <= '0;
    end else if (s2_advance) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_sign <= s1_sign;
        bus.out_zero <= s1_zero;
        bus.out_nar  <= s1_nar;
        if (s1_zero || s1_nar) begin
          bus.out_regime <= '0;
          bus.out_exp    <= '0;
          bus.out_frac   <= '0;
        end else begin
          bus.out_regime <= k_val;
          bus.out_exp    <= exp_val;
          bus.out_frac   <= frac_val;
        end
      end
    end
  end
endmodule
